// File: rtl/pe_array_ctrl.sv
// Tile sequencer for a weight-stationary systolic PE array: weight load, bank swap,
// skewed activation feed and per-column result-valid tracking until drain.
module pe_array_ctrl #(
  parameter int unsigned ROWS  = 16,
  parameter int unsigned COLS  = 16,
  parameter int unsigned LEN_W = 16
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                start,
  input  logic                reload_w,
  input  logic [LEN_W-1:0]    tile_len,
  input  logic                w_valid,
  output logic                w_ready,
  input  logic [COLS*8-1:0]   w_data,
  input  logic                act_valid,
  output logic                act_ready,
  input  logic [ROWS*8-1:0]   act_data,
  output logic                arr_en,
  output logic                arr_w_en,
  output logic                arr_selector,
  output logic [COLS*8-1:0]   arr_weight,
  output logic [ROWS*8-1:0]   arr_active,
  output logic [COLS-1:0]     col_valid,
  output logic                busy,
  output logic                done
);

  localparam int unsigned RCNT_W = $clog2(ROWS + 1);
  localparam int unsigned PIPE_D = ROWS + COLS;

  typedef enum logic [2:0] {IDLE, LOAD_W, SWAP, STREAM, DRAIN} state_t;

  state_t              state, state_nx;
  logic [RCNT_W-1:0]   rcnt;
  logic [LEN_W-1:0]    vcnt;
  logic [LEN_W-1:0]    len_q;
  logic                sel;
  logic [PIPE_D-1:0]   vpipe;
  logic                w_acc;
  logic                a_acc;
  logic                pipe_empty;

  assign pipe_empty   = (vpipe == '0);
  assign arr_en       = (state != IDLE);
  assign busy         = (state != IDLE);
  assign arr_selector = sel;
  assign col_valid    = vpipe[ROWS +: COLS];

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= state_nx;
  end

  // Next state and handshake/array controls.
  always_comb begin
    state_nx   = state;
    w_ready    = 1'b0;
    act_ready  = 1'b0;
    arr_w_en   = 1'b0;
    arr_weight = '0;
    done       = 1'b0;
    w_acc      = 1'b0;
    a_acc      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (reload_w)            state_nx = LOAD_W;
          else if (tile_len == '0) state_nx = DRAIN;
          else                     state_nx = STREAM;
        end
      end
      LOAD_W: begin
        w_ready = 1'b1;
        if (w_valid) begin
          w_acc      = 1'b1;
          arr_w_en   = 1'b1;
          arr_weight = w_data;
          if (rcnt == RCNT_W'(ROWS - 1)) state_nx = SWAP;
        end
      end
      SWAP: state_nx = (len_q == '0) ? DRAIN : STREAM;
      STREAM: begin
        act_ready = 1'b1;
        if (act_valid) begin
          a_acc = 1'b1;
          if (vcnt == len_q - LEN_W'(1)) state_nx = DRAIN;
        end
      end
      DRAIN: begin
        if (pipe_empty) begin
          done     = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Tile parameters, counters, bank selector and the result-valid pipeline.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      rcnt  <= '0;
      vcnt  <= '0;
      len_q <= '0;
      sel   <= 1'b0;
      vpipe <= '0;
    end else begin
      if (state == IDLE && start) begin
        len_q <= tile_len;
        rcnt  <= '0;
        vcnt  <= '0;
      end
      if (w_acc) rcnt <= rcnt + RCNT_W'(1);
      if (a_acc) vcnt <= vcnt + LEN_W'(1);
      if (state == SWAP) sel <= ~sel;
      vpipe <= {vpipe[PIPE_D-2:0], a_acc};
    end
  end

  // Diagonal skew: lane r passes through r+1 stages; cycles without an accept inject zero.
  for (genvar r = 0; r < ROWS; r++) begin : g_lane
    logic [7:0] stg [r+1];
    always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
        for (int i = 0; i <= r; i++) stg[i] <= 8'd0;
      end else begin
        stg[0] <= a_acc ? act_data[8*r +: 8] : 8'd0;
        for (int i = 1; i <= r; i++) stg[i] <= stg[i-1];
      end
    end
    assign arr_active[8*r +: 8] = stg[r];
  end

endmodule

// File: tb/tb_pe_array_ctrl.sv
// Bench for pe_array_ctrl: tile-level model with cycle-indexed accept history,
// per-cycle comparison, and directed tiles with hand-derived cycle expectations.
module tb_pe_array_ctrl;

  localparam int unsigned ROWS  = 16;
  localparam int unsigned COLS  = 16;
  localparam int unsigned LEN_W = 16;
  localparam int RC = ROWS + COLS;

  logic CLK, RESET, start, reload_w, w_valid, w_ready, act_valid, act_ready;
  logic [LEN_W-1:0]  tile_len;
  logic [COLS*8-1:0] w_data, arr_weight;
  logic [ROWS*8-1:0] act_data, arr_active;
  logic arr_en, arr_w_en, arr_selector, busy, done;
  logic [COLS-1:0] col_valid;

  pe_array_ctrl #(.ROWS(ROWS), .COLS(COLS), .LEN_W(LEN_W)) dut (
    .CLK(CLK), .RESET(RESET), .start(start), .reload_w(reload_w), .tile_len(tile_len),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .act_valid(act_valid), .act_ready(act_ready), .act_data(act_data),
    .arr_en(arr_en), .arr_w_en(arr_w_en), .arr_selector(arr_selector),
    .arr_weight(arr_weight), .arr_active(arr_active), .col_valid(col_valid),
    .busy(busy), .done(done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // Data sources: random weights; activations random or lane r = r+1.
  logic fixed_lanes = 1'b0;
  initial begin
    w_data = '0;
    act_data = '0;
    forever begin
      @(posedge CLK);
      #1;
      w_data = {$urandom(), $urandom(), $urandom(), $urandom()};
      if (fixed_lanes) begin
        for (int r = 0; r < ROWS; r++) act_data[8*r +: 8] = 8'(r + 1);
      end else begin
        act_data = {$urandom(), $urandom(), $urandom(), $urandom()};
      end
    end
  end

  // Tile-level model: phase plus counts; skew and validity come from the accept history.
  localparam int P_IDLE = 0, P_LOAD = 1, P_SWAP = 2, P_STREAM = 3, P_DRAIN = 4;
  int ph = P_IDLE;
  int rows_left, vec_left, len_m, done_at;
  logic sel_m = 1'b0;
  logic [ROWS*8-1:0] acc_hist [int];

  always @(negedge CLK) begin : model_cmp
    logic [ROWS*8-1:0] e_act, tmp;
    logic [COLS-1:0]   e_cv;
    logic              loading, e_wen;
    if (RESET) begin
      ph = P_IDLE;
      sel_m = 1'b0;
      acc_hist.delete();
    end
    loading = (ph == P_LOAD);
    e_wen   = loading && w_valid;
    for (int r = 0; r < ROWS; r++) begin
      if (acc_hist.exists(cyc - 1 - r)) begin
        tmp = acc_hist[cyc - 1 - r];
        e_act[8*r +: 8] = tmp[8*r +: 8];
      end else begin
        e_act[8*r +: 8] = 8'd0;
      end
    end
    for (int c = 0; c < COLS; c++) e_cv[c] = acc_hist.exists(cyc - 1 - ROWS - c);
    chk("w_ready", w_ready, loading);
    chk("arr_w_en", arr_w_en, e_wen);
    chk("arr_weight", arr_weight, e_wen ? w_data : '0);
    chk("act_ready", act_ready, ph == P_STREAM);
    chk("arr_en", arr_en, ph != P_IDLE);
    chk("busy", busy, ph != P_IDLE);
    chk("arr_selector", arr_selector, sel_m);
    chk("arr_active", arr_active, e_act);
    chk("col_valid", col_valid, e_cv);
    chk("done", done, (ph == P_DRAIN) && (cyc == done_at));
    if (!RESET) begin
      case (ph)
        P_IDLE: if (start) begin
          len_m = int'(tile_len);
          vec_left = len_m;
          if (reload_w) begin
            ph = P_LOAD;
            rows_left = ROWS;
          end else if (len_m == 0) begin
            ph = P_DRAIN;
            done_at = cyc + 1;
          end else begin
            ph = P_STREAM;
          end
        end
        P_LOAD: if (w_valid) begin
          rows_left--;
          if (rows_left == 0) ph = P_SWAP;
        end
        P_SWAP: begin
          sel_m = ~sel_m;
          if (len_m == 0) begin
            ph = P_DRAIN;
            done_at = cyc + 1;
          end else begin
            ph = P_STREAM;
          end
        end
        P_STREAM: if (act_valid) begin
          acc_hist[cyc] = act_data;
          vec_left--;
          if (vec_left == 0) begin
            ph = P_DRAIN;
            done_at = cyc + RC + 1;
          end
        end
        default: if (cyc == done_at) ph = P_IDLE;
      endcase
    end
  end

  // Event log for the literal cycle expectations.
  int wen_cnt, wen_first, acc_cnt, cv_any, cv0_first, cv0_last, cv15_first, cv15_last;
  int done_cyc, sel_chg;
  logic sel_prev = 1'b0;
  logic cv0_log [int];
  logic [7:0] lane3_log [int];

  always @(negedge CLK) begin
    if (arr_w_en) begin
      if (wen_first < 0) wen_first = cyc;
      wen_cnt++;
    end
    if (act_valid && act_ready) acc_cnt++;
    if (|col_valid) cv_any++;
    if (col_valid[0]) begin
      if (cv0_first < 0) cv0_first = cyc;
      cv0_last = cyc;
    end
    if (col_valid[COLS-1]) begin
      if (cv15_first < 0) cv15_first = cyc;
      cv15_last = cyc;
    end
    if (done && done_cyc < 0) done_cyc = cyc;
    if (arr_selector !== sel_prev && sel_chg < 0) sel_chg = cyc;
    sel_prev = arr_selector;
    cv0_log[cyc] = col_valid[0];
    lane3_log[cyc] = arr_active[31:24];
  end

  task automatic clr_log();
    wen_cnt = 0; wen_first = -1; acc_cnt = 0; cv_any = 0;
    cv0_first = -1; cv0_last = -1; cv15_first = -1; cv15_last = -1;
    done_cyc = -1; sel_chg = -1;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  int s;
  task automatic do_start(input logic rl, input int len);
    start = 1'b1;
    reload_w = rl;
    tile_len = LEN_W'(len);
    s = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (done_cyc >= 0) break;
      tick();
    end
    chk("done_seen", done_cyc >= 0, 1'b1);
    tick();
  endtask

  initial begin
    clr_log();
    RESET = 1'b1; start = 1'b0; reload_w = 1'b0; tile_len = '0;
    w_valid = 1'b0; act_valid = 1'b0;
    repeat (3) tick();
    chk("rst_busy", busy, 1'b0);
    chk("rst_arr_en", arr_en, 1'b0);
    chk("rst_sel", arr_selector, 1'b0);
    RESET = 1'b0;
    tick();

    // Reset in the middle of a weight load, then a full tile.
    w_valid = 1'b1; act_valid = 1'b1;
    do_start(1'b1, 4);
    repeat (5) tick();
    RESET = 1'b1;
    #1;
    chk("midrst_w_en", arr_w_en, 1'b0);
    chk("midrst_w_ready", w_ready, 1'b0);
    chk("midrst_sel", arr_selector, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    tick();
    RESET = 1'b0;
    tick();
    clr_log();
    do_start(1'b1, 4);
    wait_done(200);
    chk("full_wen_cnt", wen_cnt, 16);
    chk("full_wen_first", wen_first, s + 1);
    chk("full_sel_chg", sel_chg, s + 18);
    chk("full_sel_val", arr_selector, 1'b1);
    chk("full_acc_cnt", acc_cnt, 4);
    chk("full_cv0_first", cv0_first, s + 35);
    chk("full_cv0_last", cv0_last, s + 38);
    chk("full_cv15_first", cv15_first, s + 50);
    chk("full_cv15_last", cv15_last, s + 53);
    chk("full_done", done_cyc, s + 54);

    // Empty tile with weight reload: load, swap, done, no results.
    clr_log();
    do_start(1'b1, 0);
    wait_done(100);
    chk("z1_wen_cnt", wen_cnt, 16);
    chk("z1_cv_any", cv_any, 0);
    chk("z1_sel_chg", sel_chg, s + 18);
    chk("z1_done", done_cyc, s + 18);

    // Skew and bubbles: valid pattern 1,0,1,0,1 with lane r = r+1.
    fixed_lanes = 1'b1;
    act_valid = 1'b1;
    tick();
    clr_log();
    do_start(1'b0, 3);
    for (int i = 0; i < 6; i++) begin
      act_valid = (i % 2 == 0);
      tick();
    end
    wait_done(100);
    chk("skew_l3_pre", lane3_log[s + 4], 8'd0);
    chk("skew_l3_a", lane3_log[s + 5], 8'd4);
    chk("skew_l3_bub", lane3_log[s + 6], 8'd0);
    chk("skew_l3_b", lane3_log[s + 7], 8'd4);
    chk("skew_cv0_a", cv0_log[s + 18], 1'b1);
    chk("skew_cv0_gap", cv0_log[s + 19], 1'b0);
    chk("skew_cv0_b", cv0_log[s + 20], 1'b1);
    chk("skew_acc_cnt", acc_cnt, 3);
    chk("skew_done", done_cyc, s + 38);

    // Weight reuse: no load, selector untouched.
    fixed_lanes = 1'b0;
    act_valid = 1'b1;
    clr_log();
    do_start(1'b0, 2);
    wait_done(100);
    chk("reuse_wen_cnt", wen_cnt, 0);
    chk("reuse_sel_chg", sel_chg, -1);
    chk("reuse_acc_cnt", acc_cnt, 2);
    chk("reuse_done", done_cyc, s + 35);

    // Empty tile without reload finishes almost at once.
    clr_log();
    do_start(1'b0, 0);
    wait_done(10);
    chk("z0_done", done_cyc, s + 1);
    chk("z0_within2", (done_cyc - s) <= 2, 1'b1);
    chk("z0_cv_any", cv_any, 0);

    // A start while busy is ignored along with its parameters.
    clr_log();
    do_start(1'b0, 2);
    tick();
    tick();
    start = 1'b1; reload_w = 1'b1; tile_len = LEN_W'(5);
    tick();
    start = 1'b0;
    wait_done(100);
    chk("busy_start_wen", wen_cnt, 0);
    chk("busy_start_acc", acc_cnt, 2);
    chk("busy_start_done", done_cyc, s + 35);
    chk("busy_start_idle", busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
